jk_bank_ctrl: RTL and testbench

Command sequencer for a bank of WIDTH JK flip-flops (one JKFLOP cell per bit, sharing `clk`). It accepts one command at a time over a valid/ready handshake. It drives the bank's J/K inputs for the required number of cycles and reads the bank's Q outputs back. When the command finishes it reports completion and whether the bank reached the expected value. It sits between the control logic and the JK register bank and is the only driver of the bank's J/K pins.

---
 rtl/jk_bank_ctrl_if.sv | 23 ++
 rtl/jk_bank_ctrl.sv | 155 +++++++++++++++
 tb/tb_jk_bank_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/jk_bank_ctrl_if.sv
// Command handshake and status bundle between the control logic and jk_bank_ctrl.
interface jk_bank_ctrl_if #(
  parameter int unsigned WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [3:0]       cmd_rep;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_rep,
    input  cmd_ready, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_rep,
    output cmd_ready, busy, done, err
  );
endinterface

// File: rtl/jk_bank_ctrl.sv
// Command sequencer for a bank of JK flip-flops: drives J/K for N cycles, then
// checks the bank's Q against the value the command should have produced.
module jk_bank_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  jk_bank_ctrl_if.slave    cmd,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  input  logic [WIDTH-1:0] q_in
);

  localparam int unsigned CNTW = 5;

  localparam logic [2:0] OP_CLEAR  = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_TOGGLE = 3'd2;
  localparam logic [2:0] OP_INC    = 3'd3;
  localparam logic [2:0] OP_DEC    = 3'd4;
  localparam logic [2:0] OP_SET    = 3'd5;
  localparam logic [2:0] OP_RESET  = 3'd6;
  localparam logic [2:0] OP_RSVD   = 3'd7;

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

  state_t            state, state_nx;
  logic [CNTW-1:0]   cnt, cnt_nx;
  logic [2:0]        op_q;
  logic [WIDTH-1:0]  data_q, q0_q;
  logic [CNTW-1:0]   n_q, n_in;
  logic [WIDTH-1:0]  jq, kq, j_nx, k_nx;
  logic [WIDTH-1:0]  tog, exp_val;
  logic              ready_q, busy_q, done_q, err_q;
  logic              accept, err_now, arith_op;

  // {J, K} for the ops whose drive depends only on the latched mask/data
  function automatic logic [2*WIDTH-1:0] fixed_drive(logic [2:0] op, logic [WIDTH-1:0] d);
    logic [2*WIDTH-1:0] r;
    r = '0;
    case (op)
      OP_CLEAR:  r = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
      OP_LOAD:   r = {d, ~d};
      OP_TOGGLE: r = {d, d};
      OP_SET:    r = {d, {WIDTH{1'b0}}};
      OP_RESET:  r = {{WIDTH{1'b0}}, d};
      default:   r = '0;
    endcase
    return r;
  endfunction

  assign accept = (state == IDLE) && ready_q && cmd.cmd_valid;
  assign n_in   = (cmd.cmd_op == OP_TOGGLE || cmd.cmd_op == OP_INC || cmd.cmd_op == OP_DEC)
                ? CNTW'(cmd.cmd_rep) + CNTW'(1) : CNTW'(1);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    j_nx     = '0;
    k_nx     = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd.cmd_op == OP_RSVD) begin
            state_nx = DONE;
          end else begin
            state_nx     = APPLY;
            cnt_nx       = CNTW'(1);
            {j_nx, k_nx} = fixed_drive(cmd.cmd_op, cmd.cmd_data);
          end
        end
      end
      APPLY: begin
        if (cnt == n_q) begin
          state_nx = DONE;
        end else begin
          cnt_nx       = cnt + CNTW'(1);
          {j_nx, k_nx} = fixed_drive(op_q, data_q);
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Ripple carry/borrow mask: bit i toggles when all lower bits are 1 (INC) or 0 (DEC)
  always_comb begin
    logic run;
    tog = '0;
    run = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      tog[i] = run;
      run    = run & ((op_q == OP_INC) ? q_in[i] : ~q_in[i]);
    end
  end

  always_comb begin
    exp_val = q0_q;
    case (op_q)
      OP_CLEAR:  exp_val = '0;
      OP_LOAD:   exp_val = data_q;
      OP_TOGGLE: exp_val = n_q[0] ? (q0_q ^ data_q) : q0_q;
      OP_INC:    exp_val = q0_q + WIDTH'(n_q);
      OP_DEC:    exp_val = q0_q - WIDTH'(n_q);
      OP_SET:    exp_val = q0_q | data_q;
      OP_RESET:  exp_val = q0_q & ~data_q;
      default:   exp_val = q0_q;
    endcase
  end

  assign err_now  = (op_q == OP_RSVD) ? 1'b1 : (q_in != exp_val);
  assign arith_op = (state == APPLY) && (op_q == OP_INC || op_q == OP_DEC);

  // INC/DEC follow the live Q; everything else comes from registers
  assign j_out = arith_op ? tog : jq;
  assign k_out = arith_op ? tog : kq;

  assign cmd.cmd_ready = ready_q;
  assign cmd.busy      = busy_q;
  assign cmd.done      = done_q;
  assign cmd.err       = (state == DONE) ? err_now : err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= OP_CLEAR;
      data_q  <= '0;
      n_q     <= '0;
      q0_q    <= '0;
      jq      <= '0;
      kq      <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      jq      <= j_nx;
      kq      <= k_nx;
      ready_q <= (state_nx == IDLE);
      busy_q  <= (state_nx != IDLE);
      done_q  <= (state_nx == DONE);
      if (accept) begin
        op_q   <= cmd.cmd_op;
        data_q <= cmd.cmd_data;
        n_q    <= n_in;
        q0_q   <= q_in;
      end
      if (state == DONE) err_q <= err_now;
    end
  end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Self-checking bench for jk_bank_ctrl driving a behavioural JK register bank.
module tb_jk_bank_ctrl;
  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] j, k;
  logic [W-1:0] q = '0;

  int errors = 0;
  int checks = 0;

  jk_bank_ctrl_if #(.WIDTH(W)) ifc ();

  jk_bank_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .cmd   (ifc.slave),
    .j_out (j),
    .k_out (k),
    .q_in  (q)
  );

  always #5 clk = ~clk;

  // JK bank: one cell per bit, registered Q
  always @(posedge clk) begin
    for (int i = 0; i < W; i++) begin
      case ({j[i], k[i]})
        2'b10:   q[i] <= 1'b1;
        2'b01:   q[i] <= 1'b0;
        2'b11:   q[i] <= ~q[i];
        default: q[i] <= q[i];
      endcase
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] data;
    logic [3:0]   rep;
    logic [W-1:0] exp_q;
    logic         exp_err;
    int           exp_lat;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int g;
    g = 0;
    while (ifc.cmd_ready !== 1'b1 && g < 50) begin
      tick();
      g++;
    end
    if (g == 50) chk("ready_timeout", {31'd0, ifc.cmd_ready}, 32'd1);
  endtask

  task automatic drive(input logic [2:0] op, input logic [W-1:0] d, input logic [3:0] rep);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op    = op;
    ifc.cmd_data  = d;
    ifc.cmd_rep   = rep;
  endtask

  // Issues one command and returns in the cycle done is seen (or budget exhausted)
  task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] d, input logic [3:0] rep,
                         output int lat, output logic e);
    wait_ready();
    drive(op, d, rep);
    tick();
    ifc.cmd_valid = 1'b0;
    lat = 1;
    while (ifc.done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    e = ifc.err;
  endtask

  // Reference: command result from arithmetic on the start value
  function automatic logic [W-1:0] model_q(input logic [2:0] op, input logic [W-1:0] d,
                                           input logic [3:0] rep, input logic [W-1:0] q0);
    int n, r;
    n = (op == 3'd2 || op == 3'd3 || op == 3'd4) ? int'(rep) + 1 : 1;
    case (op)
      3'd0: r = 0;
      3'd1: r = int'(d);
      3'd2: r = int'(q0) ^ ((n % 2 == 1) ? int'(d) : 0);
      3'd3: r = int'(q0) + n;
      3'd4: r = int'(q0) - n;
      3'd5: r = int'(q0 | d);
      3'd6: r = int'(q0 & ~d);
      default: r = int'(q0);
    endcase
    return W'(r);
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [3:0] rep);
    if (op == 3'd7) return 1;
    if (op == 3'd2 || op == 3'd3 || op == 3'd4) return int'(rep) + 2;
    return 2;
  endfunction

  initial begin
    int           lat, dcount;
    logic         e;
    logic [W-1:0] mq, d;
    logic [2:0]   op;
    logic [3:0]   rep;

    vecs[0]  = '{3'd0, 4'b0000, 4'd0,  4'b0000, 1'b0, 2};
    vecs[1]  = '{3'd1, 4'b1110, 4'd0,  4'b1110, 1'b0, 2};
    vecs[2]  = '{3'd3, 4'b0000, 4'd2,  4'b0001, 1'b0, 4};
    vecs[3]  = '{3'd1, 4'b0001, 4'd0,  4'b0001, 1'b0, 2};
    vecs[4]  = '{3'd4, 4'b0000, 4'd1,  4'b1111, 1'b0, 3};
    vecs[5]  = '{3'd6, 4'b0101, 4'd0,  4'b1010, 1'b0, 2};
    vecs[6]  = '{3'd2, 4'b0011, 4'd2,  4'b1001, 1'b0, 4};
    vecs[7]  = '{3'd5, 4'b0100, 4'd0,  4'b1101, 1'b0, 2};
    vecs[8]  = '{3'd4, 4'b0000, 4'd0,  4'b1100, 1'b0, 2};
    vecs[9]  = '{3'd3, 4'b0000, 4'd15, 4'b1100, 1'b0, 17};
    vecs[10] = '{3'd7, 4'b1111, 4'd5,  4'b1100, 1'b1, 1};
    vecs[11] = '{3'd2, 4'b1111, 4'd0,  4'b0011, 1'b0, 2};
    vecs[12] = '{3'd1, 4'b0110, 4'd9,  4'b0110, 1'b0, 2};
    vecs[13] = '{3'd0, 4'b1111, 4'd4,  4'b0000, 1'b0, 2};
    vecs[14] = '{3'd4, 4'b0000, 4'd2,  4'b1101, 1'b0, 4};

    ifc.cmd_valid = 1'b0;
    ifc.cmd_op    = '0;
    ifc.cmd_data  = '0;
    ifc.cmd_rep   = '0;
    reset = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_ready", {31'd0, ifc.cmd_ready}, 0);
    chk("rst_busy",  {31'd0, ifc.busy}, 0);
    chk("rst_done",  {31'd0, ifc.done}, 0);
    chk("rst_err",   {31'd0, ifc.err}, 0);
    chk("rst_jk",    {24'd0, j, k}, 0);
    reset = 1'b1;
    tick();
    chk("rel_ready", {31'd0, ifc.cmd_ready}, 1);

    // Directed table
    for (int i = 0; i < 15; i++) begin
      run_cmd(vecs[i].op, vecs[i].data, vecs[i].rep, lat, e);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_q", i), {28'd0, q}, {28'd0, vecs[i].exp_q});
    end

    // LOAD 1010 from 0000: cycle-level drive
    run_cmd(3'd0, '0, 4'd0, lat, e);
    wait_ready();
    drive(3'd1, 4'b1010, 4'd0);
    tick();
    ifc.cmd_valid = 1'b0;
    chk("load_j", {28'd0, j}, 32'b1010);
    chk("load_k", {28'd0, k}, 32'b0101);
    chk("load_busy", {31'd0, ifc.busy}, 1);
    chk("load_done1", {31'd0, ifc.done}, 0);
    tick();
    chk("load_done2", {31'd0, ifc.done}, 1);
    chk("load_err", {31'd0, ifc.err}, 0);
    chk("load_q", {28'd0, q}, 32'b1010);
    chk("load_jk_idle", {24'd0, j, k}, 0);
    tick();
    chk("load_ready", {31'd0, ifc.cmd_ready}, 1);

    // TOGGLE with even repeat returns Q to its start value
    drive(3'd2, 4'b0110, 4'd1);
    tick();
    ifc.cmd_valid = 1'b0;
    chk("tog_jk1", {24'd0, j, k}, 32'b0110_0110);
    tick();
    chk("tog_jk2", {24'd0, j, k}, 32'b0110_0110);
    chk("tog_done2", {31'd0, ifc.done}, 0);
    tick();
    chk("tog_done3", {31'd0, ifc.done}, 1);
    chk("tog_q", {28'd0, q}, 32'b1010);
    chk("tog_err", {31'd0, ifc.err}, 0);

    // SET followed by reserved opcode held valid across DONE
    run_cmd(3'd1, 4'b0001, 4'd0, lat, e);
    wait_ready();
    drive(3'd5, 4'b1000, 4'd0);
    tick();
    drive(3'd7, 4'b1111, 4'd3);
    chk("set_j", {28'd0, j}, 32'b1000);
    chk("set_k", {28'd0, k}, 0);
    chk("set_ready_busy", {31'd0, ifc.cmd_ready}, 0);
    tick();
    chk("set_done", {31'd0, ifc.done}, 1);
    chk("set_err", {31'd0, ifc.err}, 0);
    chk("set_q", {28'd0, q}, 32'b1001);
    tick();
    chk("rsv_ready", {31'd0, ifc.cmd_ready}, 1);
    chk("rsv_idle_done", {31'd0, ifc.done}, 0);
    tick();
    ifc.cmd_valid = 1'b0;
    chk("rsv_done", {31'd0, ifc.done}, 1);
    chk("rsv_err", {31'd0, ifc.err}, 1);
    chk("rsv_jk", {24'd0, j, k}, 0);
    chk("rsv_busy", {31'd0, ifc.busy}, 1);
    tick();
    chk("rsv_err_hold", {31'd0, ifc.err}, 1);
    chk("rsv_q", {28'd0, q}, 32'b1001);

    // Random commands against the reference model
    mq = 4'b1001;
    for (int n = 0; n < 150; n++) begin
      op  = 3'($urandom_range(0, 7));
      d   = W'($urandom);
      rep = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) tick();
      run_cmd(op, d, rep, lat, e);
      chk($sformatf("rnd%0d_lat op%0d", n, op), lat, model_lat(op, rep));
      chk($sformatf("rnd%0d_err op%0d", n, op), {31'd0, e}, (op == 3'd7) ? 1 : 0);
      mq = model_q(op, d, rep, mq);
      chk($sformatf("rnd%0d_q op%0d", n, op), {28'd0, q}, {28'd0, mq});
    end

    // Reset during the 3rd APPLY cycle of INC x8
    run_cmd(3'd0, '0, 4'd0, lat, e);
    wait_ready();
    drive(3'd3, '0, 4'd7);
    tick();
    ifc.cmd_valid = 1'b0;
    tick();
    tick();
    chk("mid_busy_pre", {31'd0, ifc.busy}, 1);
    chk("mid_j_pre", {28'd0, j}, 32'b0001);
    reset = 1'b0;
    #1;
    chk("mid_busy", {31'd0, ifc.busy}, 0);
    chk("mid_jk", {24'd0, j, k}, 0);
    chk("mid_ready", {31'd0, ifc.cmd_ready}, 0);
    chk("mid_done", {31'd0, ifc.done}, 0);
    tick();
    tick();
    chk("mid_q_hold", {28'd0, q}, 32'b0010);
    reset = 1'b1;
    dcount = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ifc.done === 1'b1) dcount++;
    end
    chk("mid_no_done", dcount, 0);
    chk("mid_ready_after", {31'd0, ifc.cmd_ready}, 1);
    run_cmd(3'd1, 4'b0101, 4'd0, lat, e);
    chk("post_q", {28'd0, q}, 32'b0101);
    chk("post_err", {31'd0, e}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
